// File: rtl/video_pkg.sv
// Shared video definitions for the 720p frame-buffer fetch path.
// Holds the display geometry, the read burst size and the fetch FSM
// state type used by the scheduler.
package video_pkg;

    localparam int H_ACTIVE  = 1280;
    localparam int V_ACTIVE  = 720;
    localparam int BURST_LEN = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FREQ  = 2'd1,
        FWAIT = 2'd2,
        WGNT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/vga_fetch_scheduler_if.sv
// Memory-port / timing / renderer signal bundle for vga_fetch_scheduler.
// master: the scheduler (drives rd_*, buf_*_sel, wr_gnt, underrun_cnt).
// slave : timing generator, memory and renderer side.
interface vga_fetch_scheduler_if #(
    parameter int ADDR_W = 20
);
    logic              vs;
    logic              de;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic              rd_ack;
    logic              rd_done;
    logic              buf_wr_sel;
    logic              buf_rd_sel;
    logic              wr_req;
    logic              wr_gnt;
    logic              wr_done;
    logic [7:0]        underrun_cnt;

    modport master (
        input  vs, de, rd_ack, rd_done, wr_req, wr_done,
        output rd_req, rd_addr, rd_len, buf_wr_sel, buf_rd_sel, wr_gnt, underrun_cnt
    );

    modport slave (
        output vs, de, rd_ack, rd_done, wr_req, wr_done,
        input  rd_req, rd_addr, rd_len, buf_wr_sel, buf_rd_sel, wr_gnt, underrun_cnt
    );
endinterface

// File: rtl/edge_detect.sv
// Registered rise/fall pulse generator for a level that is already
// synchronous to clk. Ports: d (level in), rise/fall (one-cycle pulses).
// Pulses appear one cycle after the level change is first sampled.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
            fall <= ~d & d_q;
        end
    end

endmodule

// File: rtl/vga_fetch_scheduler.sv
// Frame-buffer port scheduler: prefetches display lines into a ping-pong line
// buffer in bursts and lends the port to the renderer when no fetch is pending.
// Ports: clk, rst (async, active-high), bus (vs/de in, rd_* burst request,
// buf_*_sel line-buffer halves, wr_req/wr_gnt/wr_done renderer, underrun_cnt).
module vga_fetch_scheduler #(
    parameter int          H_ACTIVE  = video_pkg::H_ACTIVE,
    parameter int          V_ACTIVE  = video_pkg::V_ACTIVE,
    parameter int          BURST_LEN = video_pkg::BURST_LEN,
    parameter int          ADDR_W    = 20,
    parameter int unsigned BASE_ADDR = 0
) (
    input logic                   clk,
    input logic                   rst,
    vga_fetch_scheduler_if.master bus
);

    import video_pkg::*;

    // H_ACTIVE is expected to be a whole number of bursts.
    localparam int BPL = H_ACTIVE / BURST_LEN;
    localparam int BW  = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int LW  = $clog2(V_ACTIVE + 1);

    logic vs_rise, vs_fall_unused, de_rise, de_fall;

    edge_detect u_vs_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.vs),
        .rise (vs_rise),
        .fall (vs_fall_unused)
    );

    edge_detect u_de_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.de),
        .rise (de_rise),
        .fall (de_fall)
    );

    fetch_state_t      state, state_nxt;
    logic              pend;
    logic [LW-1:0]     pend_line;
    logic              pend_half;
    logic [LW-1:0]     line_idx;
    logic [BW-1:0]     burst_idx;
    logic              abort;
    logic [1:0]        line_ready;
    logic              rd_sel;
    logic              wr_sel;
    logic [7:0]        urun;
    logic              rd_req_q;
    logic              wr_gnt_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] pend_base;

    logic drop;
    logic last_burst;
    logic fetch_start;
    logic burst_done;
    logic line_complete;
    logic de_sched;

    // A frame restart kills the rest of the current line as soon as it is
    // seen, so the same-cycle vs_rise is folded in alongside the sticky flag.
    assign drop          = abort | vs_rise;
    assign last_burst    = (burst_idx == BW'(BPL - 1));
    assign fetch_start   = (state == IDLE) && pend;
    assign burst_done    = (state == FWAIT) && bus.rd_done;
    assign line_complete = burst_done && last_burst && !drop;
    // Line just entered is fetched into the half that becomes the scan-out half.
    assign de_sched      = de_fall && ((int'(line_idx) + 1) < V_ACTIVE);
    assign pend_base     = ADDR_W'(BASE_ADDR) + ADDR_W'(pend_line) * ADDR_W'(H_ACTIVE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pend)
                    state_nxt = FREQ;
                else if (bus.wr_req)
                    state_nxt = WGNT;
            end
            FREQ: begin
                if (bus.rd_ack)
                    state_nxt = FWAIT;
            end
            FWAIT: begin
                if (bus.rd_done)
                    state_nxt = (last_burst || drop) ? IDLE : FREQ;
            end
            WGNT: begin
                if (bus.wr_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_req_q   <= 1'b0;
            wr_gnt_q   <= 1'b0;
            rd_addr_q  <= '0;
            burst_idx  <= '0;
            wr_sel     <= 1'b0;
            abort      <= 1'b0;
            pend       <= 1'b0;
            pend_line  <= '0;
            pend_half  <= 1'b0;
            line_idx   <= '0;
            rd_sel     <= 1'b0;
            line_ready <= 2'b00;
            urun       <= 8'd0;
        end else begin
            // Outputs follow the next state so both are registered and never overlap.
            rd_req_q <= (state_nxt == FREQ);
            wr_gnt_q <= (state_nxt == WGNT);

            if (fetch_start) begin
                rd_addr_q <= pend_base;
                burst_idx <= '0;
                wr_sel    <= pend_half;
                abort     <= 1'b0;
            end else begin
                if (burst_done && !last_burst && !drop) begin
                    rd_addr_q <= rd_addr_q + ADDR_W'(BURST_LEN);
                    burst_idx <= burst_idx + BW'(1);
                end
                if (vs_rise && (state == FREQ || state == FWAIT))
                    abort <= 1'b1;
            end

            // Single-entry pending slot: a newer schedule overwrites an older
            // one, including one being consumed by fetch_start this cycle.
            if (vs_rise) begin
                pend      <= 1'b1;
                pend_line <= '0;
                pend_half <= 1'b0;
            end else if (de_sched) begin
                pend      <= 1'b1;
                pend_line <= line_idx + LW'(1);
                pend_half <= ~rd_sel;
            end else if (fetch_start) begin
                pend      <= 1'b0;
            end

            if (vs_rise) begin
                line_idx <= '0;
                rd_sel   <= 1'b0;
            end else if (de_fall) begin
                if (int'(line_idx) < V_ACTIVE)
                    line_idx <= line_idx + LW'(1);
                rd_sel <= ~rd_sel;
            end

            if (vs_rise) begin
                line_ready <= 2'b00;
            end else begin
                if (de_fall)
                    line_ready[rd_sel] <= 1'b0;
                if (line_complete)
                    line_ready[wr_sel] <= 1'b1;
            end

            if (de_rise && !line_ready[rd_sel] && (urun != 8'hFF))
                urun <= urun + 8'd1;
        end
    end

    assign bus.rd_req       = rd_req_q;
    assign bus.rd_addr      = rd_addr_q;
    assign bus.rd_len       = 8'(BURST_LEN);
    assign bus.wr_gnt       = wr_gnt_q;
    assign bus.buf_wr_sel   = wr_sel;
    assign bus.buf_rd_sel   = rd_sel;
    assign bus.underrun_cnt = urun;

endmodule

// File: tb/tb_vga_fetch_scheduler.sv
// Scoreboard bench for vga_fetch_scheduler with a small geometry
// (8 pixels/line, 4-word bursts, 3 lines, base 0x100): expected bursts are
// queued with the stimulus and matched by a monitor on every accepted request.
module tb_vga_fetch_scheduler;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vga_fetch_scheduler_if #(.ADDR_W(20)) bus();

    vga_fetch_scheduler #(
        .H_ACTIVE  (8),
        .V_ACTIVE  (3),
        .BURST_LEN (4),
        .ADDR_W    (20),
        .BASE_ADDR (32'h100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [19:0] addr;
        logic        half;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests    = 0;
    int   fails    = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    logic hold_done = 1'b0;
    logic overlap   = 1'b0;
    logic gnt_early;
    int   k;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic vs_pulse();
        bus.vs = 1'b1;
        cyc(2);
        bus.vs = 1'b0;
        cyc(2);
    endtask

    task automatic de_pulse(input int n);
        bus.de = 1'b1;
        cyc(n);
        bus.de = 1'b0;
        cyc(2);
    endtask

    task automatic push_line(input int line, input logic half);
        exp_t e;
        e.addr = 20'(32'h100 + line * 8);
        e.half = half;
        exp_q.push_back(e);
        e.addr = 20'(32'h100 + line * 8 + 4);
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int target, input string name);
        int i;
        i = 0;
        while (done_cnt < target && i < 300) begin
            cyc(1);
            i++;
        end
        check(name, done_cnt, target);
        cyc(3);
    endtask

    // Monitor: every accepted burst must match the head of the expectation queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (bus.rd_req && bus.wr_gnt)
                    overlap = 1'b1;
                if (bus.rd_req && bus.rd_ack) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL burst: unexpected addr 0x%0h half %0d, no burst expected",
                                 bus.rd_addr, bus.buf_wr_sel);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (bus.rd_addr != mon_e.addr || bus.buf_wr_sel != mon_e.half) begin
                            fails++;
                            $display("FAIL burst: got addr 0x%0h half %0d, expected addr 0x%0h half %0d",
                                     bus.rd_addr, bus.buf_wr_sel, mon_e.addr, mon_e.half);
                        end
                    end
                end
            end
        end
    end

    // Memory model: rd_done three cycles after the accepting edge, held off by hold_done.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.rd_req && bus.rd_ack) begin
                repeat (3) @(posedge clk);
                while (hold_done && !rst) @(posedge clk);
                if (!rst) begin
                    #2 bus.rd_done = 1'b1;
                    done_cnt++;
                    @(posedge clk);
                    #2 bus.rd_done = 1'b0;
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        bus.vs      = 1'b0;
        bus.de      = 1'b0;
        bus.rd_ack  = 1'b1;
        bus.rd_done = 1'b0;
        bus.wr_req  = 1'b0;
        bus.wr_done = 1'b0;
        cyc(2);
        check("reset rd_req", bus.rd_req, 0);
        check("reset rd_addr", bus.rd_addr, 0);
        check("reset rd_len", bus.rd_len, 4);
        check("reset wr_gnt", bus.wr_gnt, 0);
        check("reset buf_wr_sel", bus.buf_wr_sel, 0);
        check("reset buf_rd_sel", bus.buf_rd_sel, 0);
        check("reset underrun_cnt", bus.underrun_cnt, 0);
        rst = 1'b0;
        cyc(2);

        // Frame start: line 0 into half 0.
        push_line(0, 1'b0);
        vs_pulse();
        exp_done += 2;
        wait_done(exp_done, "line0 fetch done");
        check("underrun after line0", bus.underrun_cnt, 0);

        // Three lines scanned; lines 1 and 2 prefetched, nothing after the last.
        for (int i = 0; i < 3; i++) begin
            check("buf_rd_sel before de", bus.buf_rd_sel, i % 2);
            if (i < 2)
                push_line(i + 1, 1'(i + 1));
            de_pulse(8);
            if (i < 2) begin
                exp_done += 2;
                wait_done(exp_done, "line fetch done");
            end else begin
                cyc(8);
            end
        end
        check("buf_rd_sel after frame", bus.buf_rd_sel, 1);
        check("underrun after frame", bus.underrun_cnt, 0);

        // Renderer granted while idle; a fetch scheduled meanwhile waits for wr_done.
        bus.wr_req = 1'b1;
        cyc(2);
        check("wr_gnt while idle", bus.wr_gnt, 1);
        push_line(0, 1'b0);
        vs_pulse();
        cyc(2);
        check("wr_gnt held during fetch request", bus.wr_gnt, 1);
        check("rd_req blocked by grant", bus.rd_req, 0);
        bus.wr_done = 1'b1;
        @(posedge clk);
        #2 bus.wr_done = 1'b0;
        @(negedge clk);
        check("wr_gnt after wr_done", bus.wr_gnt, 0);
        check("rd_req same cycle grant drops", bus.rd_req, 0);
        @(negedge clk);
        check("rd_req cycle after grant drops", bus.rd_req, 1);
        // wr_req still high: fetch wins, grant returns only after the line.
        exp_done += 2;
        gnt_early = 1'b0;
        k = 0;
        while (done_cnt < exp_done && k < 300) begin
            @(negedge clk);
            if (bus.wr_gnt)
                gnt_early = 1'b1;
            k++;
        end
        check("no grant during line fetch", gnt_early, 0);
        check("line fetch under wr_req", done_cnt, exp_done);
        cyc(3);
        check("wr_gnt after line", bus.wr_gnt, 1);
        bus.wr_req  = 1'b0;
        bus.wr_done = 1'b1;
        cyc(1);
        bus.wr_done = 1'b0;
        cyc(2);
        check("wr_gnt released", bus.wr_gnt, 0);

        // Withheld rd_done: the next line is not ready at its de_rise.
        hold_done = 1'b1;
        push_line(1, 1'b1);
        push_line(2, 1'b0);
        de_pulse(8);
        cyc(4);
        de_pulse(4);
        check("underrun single", bus.underrun_cnt, 1);
        hold_done = 1'b0;
        exp_done += 4;
        wait_done(exp_done, "late line fetch done");

        // Stuck fetch: every line underruns, count saturates; vs then aborts the line.
        hold_done = 1'b1;
        mon_e.addr = 20'h100;
        mon_e.half = 1'b0;
        exp_q.push_back(mon_e);
        vs_pulse();
        cyc(4);
        for (int i = 0; i < 10; i++)
            de_pulse(2);
        check("underrun counting", bus.underrun_cnt, 11);
        for (int i = 0; i < 290; i++)
            de_pulse(2);
        check("underrun saturated", bus.underrun_cnt, 255);
        push_line(0, 1'b0);
        vs_pulse();
        hold_done = 1'b0;
        exp_done += 3;
        wait_done(exp_done, "aborted line refetch done");
        check("underrun after abort", bus.underrun_cnt, 255);

        // Asynchronous reset while waiting for rd_done.
        hold_done = 1'b1;
        mon_e.addr = 20'h100;
        mon_e.half = 1'b0;
        exp_q.push_back(mon_e);
        vs_pulse();
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            cyc(1);
            k++;
        end
        check("burst issued before reset", exp_q.size(), 0);
        de_pulse(2);
        check("buf_rd_sel before reset", bus.buf_rd_sel, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async rst rd_req", bus.rd_req, 0);
        check("async rst rd_addr", bus.rd_addr, 0);
        check("async rst rd_len", bus.rd_len, 4);
        check("async rst wr_gnt", bus.wr_gnt, 0);
        check("async rst buf_wr_sel", bus.buf_wr_sel, 0);
        check("async rst buf_rd_sel", bus.buf_rd_sel, 0);
        check("async rst underrun_cnt", bus.underrun_cnt, 0);
        cyc(2);
        hold_done = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(2);
        push_line(0, 1'b0);
        vs_pulse();
        exp_done += 2;
        wait_done(exp_done, "fetch after reset done");

        cyc(5);
        check("scoreboard drained", exp_q.size(), 0);
        check("grant and read overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
